// File: rtl/thread_msg_responder.sv
// Dispatcher-side responder for CPU thread fork/stop requests. It queues each
// accepted request for the thread manager and answers it with a DONE code.
`ifndef CPU_MSG_SIZE
`define CPU_MSG_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef CPU_R_FORK_THRD
`define CPU_R_FORK_THRD 8'h01
`endif
`ifndef CPU_R_STOP_THRD
`define CPU_R_STOP_THRD 8'h02
`endif
`ifndef CPU_R_FORK_DONE
`define CPU_R_FORK_DONE 8'h81
`endif
`ifndef CPU_R_STOP_DONE
`define CPU_R_STOP_DONE 8'h82
`endif

module thread_msg_responder #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2,
  parameter int DONE_HOLD  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [`CPU_MSG_SIZE-1:0] cpu_msg_in,
  input  logic                     cpu_msg_pulse,
  input  logic [`ADDR_SIZE-1:0]    addr_in,
  input  logic [`DATA_SIZE-1:0]    data_in,
  output logic [`CPU_MSG_SIZE-1:0] cpu_msg_out,
  output logic                     disp_online,
  output logic                     q_valid,
  input  logic                     q_ready,
  output logic                     q_kind,
  output logic [`ADDR_SIZE-1:0]    q_addr,
  output logic [`DATA_SIZE-1:0]    q_data,
  output logic [15:0]              fork_cnt,
  output logic [15:0]              stop_cnt,
  output logic                     err
);
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int HOLD_W = $clog2(DONE_HOLD + 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                   state_q, state_d;
  logic [HOLD_W-1:0]        hold_q, hold_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [DEPTH_LOG2-1:0]    wr_ptr, rd_ptr;
  logic                     mem_kind [DEPTH];
  logic [`ADDR_SIZE-1:0]    mem_addr [DEPTH];
  logic [`DATA_SIZE-1:0]    mem_data [DEPTH];
  logic                     is_fork, is_stop, full, accept, bad, pop;
  logic [`CPU_MSG_SIZE-1:0] msg_d;
  logic                     disp_d;

  assign is_fork = (cpu_msg_in == `CPU_R_FORK_THRD);
  assign is_stop = (cpu_msg_in == `CPU_R_STOP_THRD);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign q_valid = (count_q != '0);
  assign pop     = q_valid & q_ready;
  // A pulse while full is always dropped, even if the head pops on the same edge.
  assign accept  = cpu_msg_pulse & (is_fork | is_stop) & (state_q == IDLE) & ~full;
  assign bad     = cpu_msg_pulse & (cpu_msg_in != '0) & ~accept;
  assign count_d = count_q + CNT_W'(accept) - CNT_W'(pop);

  assign q_kind = mem_kind[rd_ptr];
  assign q_addr = mem_addr[rd_ptr];
  assign q_data = mem_data[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACK;
          hold_d  = HOLD_W'(DONE_HOLD);
        end
      end
      ACK: begin
        if (hold_q == HOLD_W'(1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    msg_d = cpu_msg_out;
    if (accept)
      msg_d = is_fork ? `CPU_R_FORK_DONE : `CPU_R_STOP_DONE;
    else if (state_q == ACK && hold_q == HOLD_W'(1))
      msg_d = '0;
    disp_d = (state_d == IDLE) && (count_d < CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_msg_out <= '0;
      disp_online <= 1'b0;
      count_q     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fork_cnt    <= '0;
      stop_cnt    <= '0;
      err         <= 1'b0;
    end else begin
      cpu_msg_out <= msg_d;
      disp_online <= disp_d;
      count_q     <= count_d;
      if (accept) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop)    rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      if (accept && is_fork) fork_cnt <= fork_cnt + 16'd1;
      if (accept && is_stop) stop_cnt <= stop_cnt + 16'd1;
      if (bad) err <= 1'b1;
    end
  end

  // Queue payload carries no reset; q_valid alone qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_kind[wr_ptr] <= is_stop;
      mem_addr[wr_ptr] <= addr_in;
      mem_data[wr_ptr] <= data_in;
    end
  end

endmodule

// File: tb/tb_thread_msg_responder.sv
// Self-checking bench for thread_msg_responder: directed vector table, hand
// sequences for multi-cycle corners, and random traffic against a queue model.
`ifndef CPU_MSG_SIZE
`define CPU_MSG_SIZE 8
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef DATA_SIZE
`define DATA_SIZE 32
`endif
`ifndef CPU_R_FORK_THRD
`define CPU_R_FORK_THRD 8'h01
`endif
`ifndef CPU_R_STOP_THRD
`define CPU_R_STOP_THRD 8'h02
`endif
`ifndef CPU_R_FORK_DONE
`define CPU_R_FORK_DONE 8'h81
`endif
`ifndef CPU_R_STOP_DONE
`define CPU_R_STOP_DONE 8'h82
`endif

module tb_thread_msg_responder;
  localparam int DEPTH      = 4;
  localparam int DEPTH_LOG2 = 2;
  localparam int DONE_HOLD  = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [`CPU_MSG_SIZE-1:0] code = '0;
  logic                     pulse = 1'b0;
  logic [`ADDR_SIZE-1:0]    addr = '0;
  logic [`DATA_SIZE-1:0]    data = '0;
  logic                     q_ready = 1'b0;
  logic [`CPU_MSG_SIZE-1:0] cpu_msg_out;
  logic                     disp_online, q_valid, q_kind, err;
  logic [`ADDR_SIZE-1:0]    q_addr;
  logic [`DATA_SIZE-1:0]    q_data;
  logic [15:0]              fork_cnt, stop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  thread_msg_responder #(.DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2), .DONE_HOLD(DONE_HOLD)) dut (
    .clk(clk), .rst(rst), .cpu_msg_in(code), .cpu_msg_pulse(pulse),
    .addr_in(addr), .data_in(data), .cpu_msg_out(cpu_msg_out),
    .disp_online(disp_online), .q_valid(q_valid), .q_ready(q_ready),
    .q_kind(q_kind), .q_addr(q_addr), .q_data(q_data),
    .fork_cnt(fork_cnt), .stop_cnt(stop_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue of commands plus "DONE cycles still to show".
  typedef struct {
    logic                  kind;
    logic [`ADDR_SIZE-1:0] addr;
    logic [`DATA_SIZE-1:0] data;
  } ent_t;

  ent_t                     m_q[$];
  int                       m_busy;
  logic [`CPU_MSG_SIZE-1:0] m_reply;
  logic [15:0]              m_fork, m_stop;
  logic                     m_err, m_online;

  task automatic model_reset();
    m_q.delete();
    m_busy = 0; m_reply = '0; m_fork = '0; m_stop = '0; m_err = 1'b0; m_online = 1'b0;
  endtask

  task automatic model_step();
    bit req, acc;
    req = pulse && (code == `CPU_R_FORK_THRD || code == `CPU_R_STOP_THRD);
    acc = req && (m_busy == 0) && (m_q.size() < DEPTH);
    if (m_q.size() > 0 && q_ready) void'(m_q.pop_front());
    if (pulse && code != '0 && !acc) m_err = 1'b1;
    if (acc) begin
      m_q.push_back('{code == `CPU_R_STOP_THRD, addr, data});
      if (code == `CPU_R_FORK_THRD) begin m_fork++; m_reply = `CPU_R_FORK_DONE; end
      else begin m_stop++; m_reply = `CPU_R_STOP_DONE; end
      m_busy = DONE_HOLD;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    m_online = (m_busy == 0) && (m_q.size() < DEPTH);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic cmp_model(input string tag);
    check({tag, ".msg"},    32'(cpu_msg_out), 32'(m_busy > 0 ? m_reply : '0));
    check({tag, ".valid"},  32'(q_valid),     32'(m_q.size() > 0));
    check({tag, ".online"}, 32'(disp_online), 32'(m_online));
    check({tag, ".fcnt"},   32'(fork_cnt),    32'(m_fork));
    check({tag, ".scnt"},   32'(stop_cnt),    32'(m_stop));
    check({tag, ".err"},    32'(err),         32'(m_err));
    if (m_q.size() > 0) begin
      check({tag, ".kind"}, 32'(q_kind), 32'(m_q[0].kind));
      check({tag, ".addr"}, 32'(q_addr), 32'(m_q[0].addr));
      check({tag, ".data"}, 32'(q_data), 32'(m_q[0].data));
    end
  endtask

  // Inputs change on negedge; outputs are read on negedge after the posedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic wait_online();
    int n = 0;
    while (!disp_online && n < 20) begin tick(); n++; end
    check("wait_online", 32'(disp_online), 32'h1);
  endtask

  task automatic do_reset();
    rst = 1'b0; pulse = 1'b0; code = '0; q_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    check("rst.msg",    32'(cpu_msg_out), 32'h0);
    check("rst.valid",  32'(q_valid),     32'h0);
    check("rst.online", 32'(disp_online), 32'h0);
    check("rst.err",    32'(err),         32'h0);
    check("rst.fcnt",   32'(fork_cnt),    32'h0);
    rst = 1'b1;
    tick();
    check("rst.online_after", 32'(disp_online), 32'h1);
  endtask

  typedef struct {
    logic                     pulse;
    logic [`CPU_MSG_SIZE-1:0] code;
    logic [`ADDR_SIZE-1:0]    addr;
    logic [`DATA_SIZE-1:0]    data;
    logic                     rdy;
    logic [`CPU_MSG_SIZE-1:0] e_msg;
    logic                     e_valid;
    logic                     e_kind;
    logic [`ADDR_SIZE-1:0]    e_addr;
    logic [`DATA_SIZE-1:0]    e_data;
    logic                     e_online;
    logic [15:0]              e_fcnt, e_scnt;
    logic                     e_err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // Fork with hold, stop with same-cycle pop, then protocol-error codes.
    vecs[0] = '{1, `CPU_R_FORK_THRD, 32'h100, 32'h200, 0, `CPU_R_FORK_DONE, 1, 0, 32'h100, 32'h200, 0, 16'd1, 16'd0, 0};
    vecs[1] = '{0, 8'h00, 32'h0, 32'h0, 0, `CPU_R_FORK_DONE, 1, 0, 32'h100, 32'h200, 0, 16'd1, 16'd0, 0};
    vecs[2] = '{0, 8'h00, 32'h0, 32'h0, 0, 8'h00, 1, 0, 32'h100, 32'h200, 1, 16'd1, 16'd0, 0};
    vecs[3] = '{0, 8'h00, 32'h0, 32'h0, 0, 8'h00, 1, 0, 32'h100, 32'h200, 1, 16'd1, 16'd0, 0};
    vecs[4] = '{1, `CPU_R_STOP_THRD, 32'h0F0, 32'h1F0, 1, `CPU_R_STOP_DONE, 1, 1, 32'h0F0, 32'h1F0, 0, 16'd1, 16'd1, 0};
    vecs[5] = '{0, 8'h00, 32'h0, 32'h0, 1, `CPU_R_STOP_DONE, 0, 0, 32'h0, 32'h0, 0, 16'd1, 16'd1, 0};
    vecs[6] = '{0, 8'h00, 32'h0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 1, 16'd1, 16'd1, 0};
    vecs[7] = '{1, 8'h00, 32'h0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 1, 16'd1, 16'd1, 0};
    vecs[8] = '{1, 8'h55, 32'h0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 1, 16'd1, 16'd1, 1};
    vecs[9] = '{0, 8'h00, 32'h0, 32'h0, 0, 8'h00, 0, 0, 32'h0, 32'h0, 1, 16'd1, 16'd1, 1};

    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      pulse = vecs[i].pulse; code = vecs[i].code; addr = vecs[i].addr;
      data = vecs[i].data; q_ready = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d.msg", i),    32'(cpu_msg_out), 32'(vecs[i].e_msg));
      check($sformatf("vec%0d.valid", i),  32'(q_valid),     32'(vecs[i].e_valid));
      check($sformatf("vec%0d.online", i), 32'(disp_online), 32'(vecs[i].e_online));
      check($sformatf("vec%0d.fcnt", i),   32'(fork_cnt),    32'(vecs[i].e_fcnt));
      check($sformatf("vec%0d.scnt", i),   32'(stop_cnt),    32'(vecs[i].e_scnt));
      check($sformatf("vec%0d.err", i),    32'(err),         32'(vecs[i].e_err));
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d.kind", i), 32'(q_kind), 32'(vecs[i].e_kind));
        check($sformatf("vec%0d.addr", i), 32'(q_addr), 32'(vecs[i].e_addr));
        check($sformatf("vec%0d.data", i), 32'(q_data), 32'(vecs[i].e_data));
      end
    end
    pulse = 1'b0; code = '0; q_ready = 1'b0;

    // Fill the queue, then a CPU ignoring disp_online.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_online();
      pulse = 1'b1; code = `CPU_R_FORK_THRD; addr = 32'h1000 + i; data = 32'h3000 + i;
      tick();
      pulse = 1'b0;
    end
    repeat (3) tick();
    check("full.online", 32'(disp_online), 32'h0);
    check("full.valid",  32'(q_valid),     32'h1);
    check("full.fcnt",   32'(fork_cnt),    32'd4);
    pulse = 1'b1; code = `CPU_R_FORK_THRD; addr = 32'h1FFF;
    tick();
    pulse = 1'b0;
    check("full.err",    32'(err),         32'h1);
    check("full.nodone", 32'(cpu_msg_out), 32'h0);
    check("full.fcnt5",  32'(fork_cnt),    32'd4);
    tick();
    check("full.nodone2", 32'(cpu_msg_out), 32'h0);
    check("full.head",    32'(q_addr),      32'h1000);
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    check("full.pop_online", 32'(disp_online), 32'h1);
    check("full.pop_head",   32'(q_addr),      32'h1001);
    tick();
    check("full.online2", 32'(disp_online), 32'h1);
    cmp_model("full");

    // Push and pop on the same edge with two entries queued.
    q_ready = 1'b1;
    tick();
    q_ready = 1'b0;
    check("pp.head0", 32'(q_addr), 32'h1002);
    pulse = 1'b1; code = `CPU_R_STOP_THRD; addr = 32'h2000; data = 32'h4000; q_ready = 1'b1;
    tick();
    pulse = 1'b0; q_ready = 1'b0;
    check("pp.msg",  32'(cpu_msg_out), 32'(`CPU_R_STOP_DONE));
    check("pp.head", 32'(q_addr),      32'h1003);
    check("pp.scnt", 32'(stop_cnt),    32'd1);
    q_ready = 1'b1;
    tick();
    check("pp.tail_addr", 32'(q_addr), 32'h2000);
    check("pp.tail_kind", 32'(q_kind), 32'h1);
    check("pp.tail_data", 32'(q_data), 32'h4000);
    tick();
    q_ready = 1'b0;
    check("pp.empty", 32'(q_valid), 32'h0);
    cmp_model("pp");

    // Asynchronous reset during the first ACK cycle.
    wait_online();
    pulse = 1'b1; code = `CPU_R_FORK_THRD; addr = 32'h5000; data = 32'h6000;
    tick();
    pulse = 1'b0;
    check("ar.ack", 32'(cpu_msg_out), 32'(`CPU_R_FORK_DONE));
    #2 rst = 1'b0;
    #1;
    check("ar.msg",    32'(cpu_msg_out), 32'h0);
    check("ar.valid",  32'(q_valid),     32'h0);
    check("ar.online", 32'(disp_online), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("ar.online_after", 32'(disp_online), 32'h1);
    check("ar.fcnt",         32'(fork_cnt),    32'h0);
    check("ar.scnt",         32'(stop_cnt),    32'h0);
    check("ar.err",          32'(err),         32'h0);

    // Random traffic, mostly well-behaved CPUs with occasional rule breakers.
    for (int c = 0; c < 600; c++) begin
      int r;
      r = $urandom_range(0, 15);
      pulse = 1'b0; code = '0;
      addr = $urandom(); data = $urandom();
      q_ready = ($urandom_range(0, 2) != 0);
      if (r == 0) begin
        pulse = 1'b1;
        case ($urandom_range(0, 3))
          0: code = 8'h00;
          1: code = `CPU_R_FORK_THRD;
          2: code = `CPU_R_STOP_THRD;
          default: code = 8'h55;
        endcase
      end else if (m_online && r < 7) begin
        pulse = 1'b1;
        code = r[0] ? `CPU_R_FORK_THRD : `CPU_R_STOP_THRD;
      end
      tick();
      cmp_model("rnd");
    end
    pulse = 1'b0; code = '0; q_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
